// File: rtl/kronos_wb_lsu.sv
// kronos_wb_lsu: write-back / load-store stage. This stage retires one instruction at a time.
// ALU results are written back on the cycle after they are accepted. Aligned loads and stores
// run a request/acknowledge data-bus transaction. Misaligned accesses are flagged and dropped.
module kronos_wb_lsu #(
    parameter int BUS_AW = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              execute_vld,
    output logic              execute_rdy,
    input  logic [31:0]       result1,
    input  logic [31:0]       result2,
    input  logic [4:0]        rd,
    input  logic              rd_write,
    input  logic              ld,
    input  logic              st,
    input  logic [1:0]        data_size,
    input  logic              data_uns,
    output logic [31:0]       regwr_data,
    output logic [4:0]        regwr_sel,
    output logic              regwr_en,
    output logic [BUS_AW-1:0] data_addr,
    output logic [31:0]       data_wr_data,
    output logic [3:0]        data_mask,
    output logic              data_wr_en,
    output logic              data_req,
    input  logic              data_ack,
    input  logic [31:0]       data_rd_data,
    output logic              ld_misaligned,
    output logic              st_misaligned
);

    typedef enum logic [1:0] {IDLE, BUS, DONE} state_t;

    state_t             state_q, state_d;
    logic [31:0]        regwr_data_q, regwr_data_d;
    logic [4:0]         regwr_sel_q, regwr_sel_d;
    logic               regwr_en_q, regwr_en_d;
    logic [BUS_AW-1:0]  data_addr_q, data_addr_d;
    logic [31:0]        data_wr_data_q, data_wr_data_d;
    logic [3:0]         data_mask_q, data_mask_d;
    logic               data_wr_en_q, data_wr_en_d;
    logic               ld_mis_q, ld_mis_d;
    logic               st_mis_q, st_mis_d;
    logic [1:0]         offset_q, offset_d;
    logic [1:0]         size_q, size_d;
    logic               uns_q, uns_d;
    logic [4:0]         rd_q, rd_d;

    // Pull the addressed byte/half/word out of the bus word and sign- or zero-extend it.
    function automatic logic [31:0] load_extract(input logic [31:0] rdata, input logic [1:0] off,
                                                 input logic [1:0] size, input logic uns);
        logic [31:0] sh;
        sh = rdata >> {off, 3'b000};
        case (size)
            2'b00:   load_extract = uns ? {24'b0, sh[7:0]}  : {{24{sh[7]}}, sh[7:0]};
            2'b01:   load_extract = uns ? {16'b0, sh[15:0]} : {{16{sh[15]}}, sh[15:0]};
            default: load_extract = sh;
        endcase
    endfunction

    // Byte enables for a store of the given size at the given byte offset.
    function automatic logic [3:0] store_mask(input logic [1:0] off, input logic [1:0] size);
        case (size)
            2'b00:   store_mask = 4'b0001 << off;
            2'b01:   store_mask = 4'b0011 << off;
            default: store_mask = 4'b1111;
        endcase
    endfunction

    logic is_mem;
    logic misaligned;
    assign is_mem     = ld | st;
    assign misaligned = (data_size == 2'b01 && result1[0]) ||
                        (data_size[1] && result1[1:0] != 2'b00);

    // Next-state and registered-output logic. ld wins when ld and st are both set.
    always_comb begin
        state_d        = state_q;
        regwr_data_d   = regwr_data_q;
        regwr_sel_d    = regwr_sel_q;
        regwr_en_d     = 1'b0;
        data_addr_d    = data_addr_q;
        data_wr_data_d = data_wr_data_q;
        data_mask_d    = data_mask_q;
        data_wr_en_d   = data_wr_en_q;
        ld_mis_d       = 1'b0;
        st_mis_d       = 1'b0;
        offset_d       = offset_q;
        size_d         = size_q;
        uns_d          = uns_q;
        rd_d           = rd_q;
        case (state_q)
            IDLE: begin
                if (execute_vld) begin
                    if (!is_mem) begin
                        regwr_en_d   = rd_write && (rd != 5'd0);
                        regwr_data_d = result1;
                        regwr_sel_d  = rd;
                    end else if (misaligned) begin
                        ld_mis_d = ld;
                        st_mis_d = st & ~ld;
                    end else begin
                        data_addr_d    = {result1[BUS_AW-1:2], 2'b00};
                        data_wr_en_d   = ~ld;
                        data_mask_d    = ld ? 4'b1111 : store_mask(result1[1:0], data_size);
                        data_wr_data_d = result2 << {result1[1:0], 3'b000};
                        offset_d       = result1[1:0];
                        size_d         = data_size;
                        uns_d          = data_uns;
                        rd_d           = rd;
                        state_d        = BUS;
                    end
                end
            end
            BUS: begin
                if (data_ack) begin
                    state_d = DONE;
                    if (!data_wr_en_q) begin
                        regwr_en_d   = (rd_q != 5'd0);
                        regwr_data_d = load_extract(data_rd_data, offset_q, size_q, uns_q);
                        regwr_sel_d  = rd_q;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers; reset clears everything so an in-flight access is abandoned.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= IDLE;
            regwr_data_q   <= '0;
            regwr_sel_q    <= '0;
            regwr_en_q     <= 1'b0;
            data_addr_q    <= '0;
            data_wr_data_q <= '0;
            data_mask_q    <= '0;
            data_wr_en_q   <= 1'b0;
            ld_mis_q       <= 1'b0;
            st_mis_q       <= 1'b0;
            offset_q       <= '0;
            size_q         <= '0;
            uns_q          <= 1'b0;
            rd_q           <= '0;
        end else begin
            state_q        <= state_d;
            regwr_data_q   <= regwr_data_d;
            regwr_sel_q    <= regwr_sel_d;
            regwr_en_q     <= regwr_en_d;
            data_addr_q    <= data_addr_d;
            data_wr_data_q <= data_wr_data_d;
            data_mask_q    <= data_mask_d;
            data_wr_en_q   <= data_wr_en_d;
            ld_mis_q       <= ld_mis_d;
            st_mis_q       <= st_mis_d;
            offset_q       <= offset_d;
            size_q         <= size_d;
            uns_q          <= uns_d;
            rd_q           <= rd_d;
        end
    end

    assign execute_rdy   = (state_q == IDLE);
    assign data_req      = (state_q == BUS);
    assign regwr_data    = regwr_data_q;
    assign regwr_sel     = regwr_sel_q;
    assign regwr_en      = regwr_en_q;
    assign data_addr     = data_addr_q;
    assign data_wr_data  = data_wr_data_q;
    assign data_mask     = data_mask_q;
    assign data_wr_en    = data_wr_en_q;
    assign ld_misaligned = ld_mis_q;
    assign st_misaligned = st_mis_q;

endmodule

// File: tb/tb_kronos_wb_lsu.sv
// Testbench for kronos_wb_lsu: directed scenarios followed by random instructions, checked by a scoreboard.
module tb_kronos_wb_lsu;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        execute_vld = 1'b0;
    logic        execute_rdy;
    logic [31:0] result1 = '0, result2 = '0;
    logic [4:0]  rd = '0;
    logic        rd_write = 1'b0, ld = 1'b0, st = 1'b0;
    logic [1:0]  data_size = '0;
    logic        data_uns = 1'b0;
    logic [31:0] regwr_data;
    logic [4:0]  regwr_sel;
    logic        regwr_en;
    logic [31:0] data_addr;
    logic [31:0] data_wr_data;
    logic [3:0]  data_mask;
    logic        data_wr_en, data_req;
    logic        data_ack = 1'b0;
    logic [31:0] data_rd_data = '0;
    logic        ld_misaligned, st_misaligned;

    kronos_wb_lsu #(.BUS_AW(32)) dut (
        .clk(clk), .rst(rst), .execute_vld(execute_vld), .execute_rdy(execute_rdy),
        .result1(result1), .result2(result2), .rd(rd), .rd_write(rd_write), .ld(ld), .st(st),
        .data_size(data_size), .data_uns(data_uns), .regwr_data(regwr_data), .regwr_sel(regwr_sel),
        .regwr_en(regwr_en), .data_addr(data_addr), .data_wr_data(data_wr_data), .data_mask(data_mask),
        .data_wr_en(data_wr_en), .data_req(data_req), .data_ack(data_ack), .data_rd_data(data_rd_data),
        .ld_misaligned(ld_misaligned), .st_misaligned(st_misaligned)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [36:0] exp_wb[$];   // {sel, data}
    logic [1:0]  exp_mis[$];  // {ld_misaligned, st_misaligned}
    logic [68:0] exp_bus[$];  // {addr, wr_en, mask, wdata}
    logic        prev_bus = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Reference model for a load result, using plain arithmetic on the returned word.
    function automatic logic [31:0] model_load(input logic [31:0] rdata, input int off,
                                               input logic [1:0] size, input logic uns);
        logic [31:0] v;
        if (size == 2'b00) begin
            v = (rdata / (32'd1 << (8 * off))) % 256;
            if (!uns && v >= 128) v = v + 32'hFFFF_FF00;
        end else if (size == 2'b01) begin
            v = (rdata / (32'd1 << (8 * off))) % 65536;
            if (!uns && v >= 32768) v = v + 32'hFFFF_0000;
        end else begin
            v = rdata;
        end
        return v;
    endfunction

    // Issue one instruction, record its expected effects, and act as the bus slave if needed.
    task automatic issue(input logic [31:0] r1, input logic [31:0] r2, input logic [4:0] rdi,
                         input logic rw, input logic l, input logic s, input logic [1:0] sz,
                         input logic un, input int waits, input logic [31:0] rdata, input logic stray);
        int  guard;
        int  off;
        bit  mem, mis, isst;
        logic [3:0] m;
        @(negedge clk);
        if (!prev_bus) check("rdy_immediate", {63'b0, execute_rdy}, 64'd1);
        guard = 0;
        while (!execute_rdy && guard < 20) begin
            guard++;
            @(negedge clk);
        end
        if (!execute_rdy) begin
            check("rdy_timeout", 64'd0, 64'd1);
            return;
        end
        result1 = r1; result2 = r2; rd = rdi; rd_write = rw; ld = l; st = s;
        data_size = sz; data_uns = un; execute_vld = 1'b1; data_ack = stray;
        off  = int'(r1[1:0]);
        mem  = l || s;
        isst = s && !l;
        mis  = mem && ((sz == 2'b01 && (off % 2) == 1) || (sz >= 2'd2 && off != 0));
        if (!mem) begin
            if (rw && rdi != 0) exp_wb.push_back({rdi, r1});
        end else if (mis) begin
            exp_mis.push_back({l, isst});
        end else begin
            m = (sz == 2'b00) ? 4'(1 << off) : (sz == 2'b01) ? 4'(3 << off) : 4'hF;
            if (l) m = 4'hF;
            exp_bus.push_back({r1 - 32'(off), isst, m, 32'(r2 * (32'd1 << (8 * off)))});
            if (l && rdi != 0) exp_wb.push_back({rdi, model_load(rdata, off, sz, un)});
        end
        @(posedge clk);
        #1;
        execute_vld = 1'b0;
        data_ack    = 1'b0;
        prev_bus    = mem && !mis;
        if (mem && !mis) begin
            @(negedge clk);
            repeat (waits) @(negedge clk);
            guard = 0;
            while (!data_req && guard < 10) begin
                guard++;
                @(negedge clk);
            end
            if (!data_req) begin
                check("req_timeout", 64'd0, 64'd1);
                return;
            end
            data_ack = 1'b1;
            data_rd_data = rdata;
            @(posedge clk);
            #1;
            data_ack = 1'b0;
            @(negedge clk);
            check("rdy_in_done", {63'b0, execute_rdy}, 64'd0);
            check("req_after_ack", {63'b0, data_req}, 64'd0);
            @(negedge clk);
            check("rdy_back", {63'b0, execute_rdy}, 64'd1);
        end
    endtask

    logic [68:0] held;
    logic        req_prev = 1'b0;

    // Monitor: compare every DUT output event against the head of its expectation queue.
    always @(negedge clk) begin
        logic [36:0] e;
        logic [1:0]  em;
        logic [68:0] eb;
        logic [68:0] cur;
        if (regwr_en) begin
            checks++;
            if (exp_wb.size() == 0) begin
                errors++;
                $display("FAIL regwr_spurious: got sel=%0d data=%h, expected no write", regwr_sel, regwr_data);
            end else begin
                e = exp_wb.pop_front();
                if ({regwr_sel, regwr_data} !== e) begin
                    errors++;
                    $display("FAIL regwr: got sel=%0d data=%h, expected sel=%0d data=%h",
                             regwr_sel, regwr_data, e[36:32], e[31:0]);
                end
            end
        end
        if (ld_misaligned || st_misaligned) begin
            checks++;
            if (exp_mis.size() == 0) begin
                errors++;
                $display("FAIL mis_spurious: got ld=%0b st=%0b, expected none", ld_misaligned, st_misaligned);
            end else begin
                em = exp_mis.pop_front();
                if ({ld_misaligned, st_misaligned} !== em) begin
                    errors++;
                    $display("FAIL misaligned: got %b, expected %b", {ld_misaligned, st_misaligned}, em);
                end
            end
        end
        cur = {data_addr, data_wr_en, data_mask, data_wr_data};
        if (data_req && !req_prev) begin
            checks++;
            if (exp_bus.size() == 0) begin
                errors++;
                $display("FAIL bus_spurious: got req addr=%h, expected no request", data_addr);
            end else begin
                eb = exp_bus.pop_front();
                if (cur[68:32] !== eb[68:32] || (eb[36] && cur[31:0] !== eb[31:0])) begin
                    errors++;
                    $display("FAIL bus_req: got addr=%h we=%b mask=%b wd=%h, expected addr=%h we=%b mask=%b wd=%h",
                             cur[68:37], cur[36], cur[35:32], cur[31:0], eb[68:37], eb[36], eb[35:32], eb[31:0]);
                end
            end
            held = cur;
        end else if (data_req && req_prev) begin
            checks++;
            if (cur !== held) begin
                errors++;
                $display("FAIL bus_stable: got %h, expected %h", cur, held);
            end
        end
        req_prev = data_req;
    end

    initial begin
        int kind;
        logic [31:0] a;
        repeat (3) @(negedge clk);
        check("reset_outputs",
              {regwr_data, regwr_sel, regwr_en, data_req, data_wr_en, data_mask, ld_misaligned, st_misaligned, execute_rdy},
              {32'd0, 5'd0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1});
        check("reset_bus", {data_addr, data_wr_data}, 64'd0);
        rst = 1'b0;

        // ALU write-back and rd == 0 suppression, back to back
        issue(32'hDEADBEEF, 32'h0, 5'd5, 1'b1, 1'b0, 1'b0, 2'b10, 1'b0, 0, 32'h0, 1'b0);
        issue(32'hDEADBEEF, 32'h0, 5'd0, 1'b1, 1'b0, 1'b0, 2'b10, 1'b0, 0, 32'h0, 1'b0);
        // Signed and unsigned byte loads with two wait states
        issue(32'h1003, 32'h0, 5'd7, 1'b1, 1'b1, 1'b0, 2'b00, 1'b0, 2, 32'h80AABBCC, 1'b0);
        issue(32'h1003, 32'h0, 5'd8, 1'b1, 1'b1, 1'b0, 2'b00, 1'b1, 2, 32'h80AABBCC, 1'b0);
        // Half store on the upper lanes
        issue(32'h2002, 32'h1234ABCD, 5'd9, 1'b0, 1'b0, 1'b1, 2'b01, 1'b0, 1, 32'h0, 1'b0);
        // Misaligned word load, then an ALU op that must be accepted immediately
        issue(32'h3001, 32'h0, 5'd10, 1'b1, 1'b1, 1'b0, 2'b10, 1'b0, 0, 32'h0, 1'b0);
        issue(32'h0000_0042, 32'h0, 5'd11, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 0, 32'h0, 1'b1);
        // Zero-wait word load
        issue(32'h4000, 32'h0, 5'd12, 1'b1, 1'b1, 1'b0, 2'b10, 1'b0, 0, 32'hCAFEF00D, 1'b0);
        // Stray ack while idle
        @(negedge clk);
        data_ack = 1'b1;
        @(posedge clk);
        #1 data_ack = 1'b0;
        @(negedge clk);
        check("stray_ack_idle", {62'b0, execute_rdy, data_req}, 64'd2);

        // Reset while waiting for ack
        @(negedge clk);
        result1 = 32'h5000; rd = 5'd13; ld = 1'b1; st = 1'b0; data_size = 2'b10; execute_vld = 1'b1;
        exp_bus.push_back({32'h5000, 1'b0, 4'hF, 32'h0});
        @(posedge clk);
        #1 execute_vld = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("rst_req_drop", {63'b0, data_req}, 64'd0);
        check("rst_outputs",
              {regwr_data, regwr_sel, regwr_en, data_wr_en, data_mask, ld_misaligned, st_misaligned, execute_rdy},
              {32'd0, 5'd0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1});
        check("rst_bus", {data_addr, data_wr_data}, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        prev_bus = 1'b0;
        issue(32'h6004, 32'h0, 5'd14, 1'b1, 1'b1, 1'b0, 2'b10, 1'b0, 1, 32'h1357_9BDF, 1'b0);

        // Random instruction mix
        for (int i = 0; i < 300; i++) begin
            kind = $urandom_range(0, 3);
            a = $urandom;
            issue(a, $urandom, 5'($urandom_range(0, 31)), 1'($urandom), kind == 1 || kind == 3,
                  kind == 2 || kind == 3, 2'($urandom), 1'($urandom), $urandom_range(0, 3),
                  $urandom, 1'($urandom_range(0, 3) == 0));
        end

        repeat (4) @(negedge clk);
        check("wb_queue_empty", 64'(exp_wb.size()), 64'd0);
        check("mis_queue_empty", 64'(exp_mis.size()), 64'd0);
        check("bus_queue_empty", 64'(exp_bus.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got no finish, expected finish");
        $fatal(1, "timeout");
    end

endmodule
